irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Platform external-interrupt controller; sits directly upstream of the CSR unit.
- Collects NUM_IRQ peripheral request lines and drives the single machine-external-interrupt line, meip_o, into the CSR unit.
- Consumes the CSR unit's ack pulse to claim the winning source, then waits for a software completion write.
- Memory-mapped on the data bus: enable, pending, claim/complete and edge-mode registers.

Parameters:
- NUM_IRQ, 8, number of request sources (1..31).
- SYNC_STAGES, 2, synchroniser depth on each irq_i bit (>=2).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  reset.
- irq_i  in  NUM_IRQ  asynchronous peripheral requests.
- ack_i  in  1  interrupt-taken pulse from the CSR unit; one cycle high.
- sel_i  in  1  bus select for this block.
- wen_i  in  1  write strobe, qualified by sel_i.
- addr_i  in  4  byte address; only [3:2] decoded.
- wdata_i  in  32  write data.
- rdata_o  out  32  registered read data.
- meip_o  out  1  external interrupt request to the CSR unit.
- claim_id_o  out  5  currently claimed ID; 0 = none.

Behaviour:
- Reset: reset_i is asynchronous, active-low; clock is clk_i. During reset all registers, synchronisers and FSM clear; meip_o=0, rdata_o=0, claim_id_o=0.
- Source ID = index+1. ID 0 means "no interrupt".
- Input path:
  - irq_i goes through a SYNC_STAGES flop chain, plus one extra flop for edge detection.
  - EDGE[k]=1: PEND[k] sets on a synchronised 0->1 transition.
  - EDGE[k]=0 (level): PEND[k] sets while the synchronised level is 1.
- Registers (addr_i[3:2]):
  - 0 ENABLE, RW, bits [NUM_IRQ-1:0].
  - 1 PENDING, read = PEND; write-1-to-clear, edge sources only (ignored for level sources).
  - 2 CLAIM, read = claim_id; write = completion (see FSM).
  - 3 EDGE, RW.
  - Unused bits read 0.
- Reads: rdata_o updates on the clock edge after sel_i & !wen_i (1-cycle latency); otherwise it holds its value.
- Arbitration: fixed priority, lowest index wins among PEND & ENABLE. The winner is evaluated combinationally every cycle.
- FSM:
  - IDLE:
    - any PEND&ENABLE -> ASSERT; meip_o <= 1.
  - ASSERT:
    - ack_i=1 -> CLAIMED. claim_id <= current winner ID. If the winner is an edge source, clear its PEND bit. meip_o <= 0.
    - ack_i=0 and no PEND&ENABLE left (enable cleared or W1C) -> IDLE; meip_o <= 0.
  - CLAIMED:
    - meip_o held 0; further sources stay pending.
    - Write to CLAIM with wdata_i[4:0]==claim_id -> IDLE; claim_id <= 0.
    - A mismatching write is ignored.
    - Re-arbitration happens from IDLE on the following cycle.
- ack_i in IDLE or CLAIMED is ignored.
- meip_o is registered (glitch-free); the CSR unit samples it on the falling edge.
- Simultaneous events:
  - Edge set and W1C/claim-clear on the same bit in the same cycle: set wins (no lost edge).
  - Bus write and ack_i in the same cycle: both take effect; the claim uses the pre-write winner.
  - Level source deasserted before ack_i: if another source is pending, the claim takes it; if none, the FSM returns to IDLE and no claim occurs.
- Reset mid-operation (any state): returns to IDLE with all pending state lost.

Decomposition:
- Shared package: register offset constants (ENABLE=0, PENDING=1, CLAIM=2, EDGE=3), FSM state encoding (IDLE/ASSERT/CLAIMED, 2 bits), ID width constant 5.
- One natural sub-module, irq_sync_edge: parameterised synchroniser plus rising-edge detector for one bit, instantiated NUM_IRQ times via generate.

Test Plan:
- Edge source 3 enabled, EDGE=0x08; pulse irq_i[3] for 1 cycle -> PENDING reads 0x08 after sync; meip_o=1 within SYNC_STAGES+2 cycles; ack_i pulse -> meip_o=0, CLAIM reads 4, PENDING reads 0; write CLAIM=4 -> IDLE.
- irq_i[1] and irq_i[5] rise together, both enabled, edge mode -> first claim ID 2; after completion meip_o re-asserts and the second claim ID is 6.
- Level source 0, irq_i[0] held high through completion -> meip_o re-asserts the cycle after the CLAIM write; drop irq_i[0] -> PENDING bit 0 clears after sync delay.
- In ASSERT, clear ENABLE to 0 before ack_i -> meip_o=0 next cycle, FSM IDLE; a late ack_i is ignored and CLAIM reads 0.
- In CLAIMED with ID 4, write CLAIM=2 -> ignored, CLAIM still reads 4; new edge on irq_i[0] -> PEND set, meip_o stays 0 until the correct completion.
- Assert reset_i low mid-CLAIMED with pending bits set -> meip_o=0, rdata_o=0, all registers 0 immediately (asynchronously); no spurious meip_o after release.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared register map, FSM encoding and ID width for the interrupt controller
package irq_controller_pkg;

    localparam int ID_W = 5;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_EDGE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

endpackage

// File: rtl/irq_controller_sync_edge.sv
// irq_sync_edge: multi-flop synchroniser for one async request bit plus rising-edge detect
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // shift the async bit through the chain, then keep one delayed copy for edge detection
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// irq_controller: external-interrupt controller driving meip_o with claim/complete handshake
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               ack_i,
    input  logic               sel_i,
    input  logic               wen_i,
    input  logic [3:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               meip_o,
    output logic [ID_W-1:0]    claim_id_o
);

    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_pend;
    logic [ID_W-1:0]    r_claim_id;
    logic [31:0]        r_rdata;
    logic               r_meip;
    state_t             r_state;

    logic [NUM_IRQ-1:0] w_level;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_act;
    logic [NUM_IRQ-1:0] w_win_oh;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_clr;
    logic [ID_W-1:0]    w_win_id;
    logic [1:0]         w_reg;
    logic               w_wr;
    logic               w_take;
    logic [31:0]        w_rd_val;
    logic               w_unused;

    genvar k;
    generate
        for (k = 0; k < NUM_IRQ; k++) begin : g_sync
            irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .i_d     (irq_i[k]),
                .o_level (w_level[k]),
                .o_rise  (w_rise[k])
            );
        end
    endgenerate

    assign w_reg    = addr_i[3:2];
    assign w_wr     = sel_i & wen_i;
    assign w_act    = r_pend & r_enable;
    assign w_win_oh = w_act & (-w_act);
    assign w_take   = (r_state == ST_ASSERT) & ack_i & (|w_act);
    assign w_w1c    = (w_wr && w_reg == REG_PENDING) ? (wdata_i[NUM_IRQ-1:0] & r_edge) : '0;
    assign w_clr    = w_w1c | (w_take ? (w_win_oh & r_edge) : '0);
    assign w_rd_val = (w_reg == REG_ENABLE)  ? 32'(r_enable)   :
                      (w_reg == REG_PENDING) ? 32'(r_pend)     :
                      (w_reg == REG_CLAIM)   ? 32'(r_claim_id) : 32'(r_edge);
    assign w_unused = ^{addr_i[1:0], wdata_i};

    // fixed priority: lowest active index wins, reported as index+1
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_act[i]) w_win_id = ID_W'(i + 1);
        end
    end

    // pending bits: edge sources latch rises (a new rise beats a clear), level sources track the input
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_pend <= '0;
        else          r_pend <= (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & w_level);
    end

    // software-visible enable and edge-mode registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_enable <= '0;
            r_edge   <= '0;
        end else if (w_wr) begin
            if (w_reg == REG_ENABLE) r_enable <= wdata_i[NUM_IRQ-1:0];
            if (w_reg == REG_EDGE)   r_edge   <= wdata_i[NUM_IRQ-1:0];
        end
    end

    // registered read data, updated only on a read access
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)              r_rdata <= '0;
        else if (sel_i && !wen_i)  r_rdata <= w_rd_val;
    end

    // claim/complete handshake; meip is registered so the CSR unit sees a clean level
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_meip     <= 1'b0;
            r_claim_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_act) begin
                        r_state <= ST_ASSERT;
                        r_meip  <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (!(|w_act)) begin
                        r_state <= ST_IDLE;
                        r_meip  <= 1'b0;
                    end else if (ack_i) begin
                        r_state    <= ST_CLAIMED;
                        r_claim_id <= w_win_id;
                        r_meip     <= 1'b0;
                    end
                end
                ST_CLAIMED: begin
                    if (w_wr && w_reg == REG_CLAIM && wdata_i[ID_W-1:0] == r_claim_id) begin
                        r_state    <= ST_IDLE;
                        r_claim_id <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_meip     <= 1'b0;
                    r_claim_id <= '0;
                end
            endcase
        end
    end

    assign rdata_o    = r_rdata;
    assign meip_o     = r_meip;
    assign claim_id_o = r_claim_id;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;

    localparam logic [3:0] A_EN = 4'h0, A_PEND = 4'h4, A_CLAIM = 4'h8, A_EDGE = 4'hC;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [7:0]  irq_i = '0;
    logic        ack_i = 1'b0;
    logic        sel_i = 1'b0;
    logic        wen_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        meip_o;
    logic [4:0]  claim_id_o;

    int n_tot = 0;
    int n_bad = 0;

    irq_controller #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .irq_i      (irq_i),
        .ack_i      (ack_i),
        .sel_i      (sel_i),
        .wen_i      (wen_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .meip_o     (meip_o),
        .claim_id_o (claim_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel_i = 1'b1; wen_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        sel_i = 1'b0; wen_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        sel_i = 1'b1; wen_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        sel_i = 1'b0;
        chk(tag, rdata_o, exp);
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_i = m;
        @(negedge clk_i);
        irq_i = '0;
    endtask

    task automatic ack();
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
    endtask

    task automatic wait_meip(input string tag, input logic exp, input int budget);
        int n = 0;
        while (meip_o !== exp && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, 32'(meip_o), 32'(exp));
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_meip", 32'(meip_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_claim", 32'(claim_id_o), 0);
        reset_i = 1'b1;
        @(negedge clk_i);

        wr(A_EN, 32'h08);
        wr(A_EDGE, 32'h08);
        pulse(8'h08);
        wait_meip("t1_meip_on", 1'b1, 4);
        rd_chk("t1_pend", A_PEND, 32'h08);
        ack();
        chk("t1_meip_off", 32'(meip_o), 0);
        chk("t1_claim_id", 32'(claim_id_o), 4);
        rd_chk("t1_claim_rd", A_CLAIM, 4);
        rd_chk("t1_pend_clr", A_PEND, 0);
        wr(A_CLAIM, 4);
        chk("t1_done_id", 32'(claim_id_o), 0);
        repeat (2) @(negedge clk_i);
        chk("t1_quiet", 32'(meip_o), 0);

        wr(A_EN, 32'h22);
        wr(A_EDGE, 32'h22);
        pulse(8'h22);
        wait_meip("t2_meip_a", 1'b1, 4);
        ack();
        chk("t2_claim_a", 32'(claim_id_o), 2);
        rd_chk("t2_pend_a", A_PEND, 32'h20);
        wr(A_CLAIM, 2);
        wait_meip("t2_meip_b", 1'b1, 2);
        ack();
        chk("t2_claim_b", 32'(claim_id_o), 6);
        wr(A_CLAIM, 6);
        rd_chk("t2_pend_b", A_PEND, 0);

        wr(A_EDGE, 32'h00);
        wr(A_EN, 32'h01);
        irq_i = 8'h01;
        wait_meip("t3_meip_on", 1'b1, 6);
        ack();
        chk("t3_claim", 32'(claim_id_o), 1);
        wr(A_CLAIM, 1);
        chk("t3_meip_idle", 32'(meip_o), 0);
        @(negedge clk_i);
        chk("t3_meip_rearm", 32'(meip_o), 1);
        ack();
        chk("t3_claim2", 32'(claim_id_o), 1);
        irq_i = 8'h00;
        rd_chk("t3_pend_hold", A_PEND, 32'h01);
        repeat (3) @(negedge clk_i);
        rd_chk("t3_pend_drop", A_PEND, 0);
        wr(A_CLAIM, 1);
        repeat (3) @(negedge clk_i);
        chk("t3_meip_quiet", 32'(meip_o), 0);
        chk("t3_claim_none", 32'(claim_id_o), 0);

        wr(A_EDGE, 32'h01);
        pulse(8'h01);
        wait_meip("t4_meip_on", 1'b1, 4);
        wr(A_EN, 32'h00);
        @(negedge clk_i);
        chk("t4_meip_drop", 32'(meip_o), 0);
        ack();
        chk("t4_late_ack", 32'(claim_id_o), 0);
        rd_chk("t4_claim_rd", A_CLAIM, 0);
        wr(A_PEND, 32'h01);
        rd_chk("t4_w1c", A_PEND, 0);

        wr(A_EN, 32'h09);
        wr(A_EDGE, 32'h09);
        pulse(8'h08);
        wait_meip("t5_meip_on", 1'b1, 4);
        ack();
        chk("t5_claim", 32'(claim_id_o), 4);
        wr(A_CLAIM, 2);
        rd_chk("t5_bad_cmpl", A_CLAIM, 4);
        pulse(8'h01);
        repeat (4) @(negedge clk_i);
        rd_chk("t5_pend0", A_PEND, 32'h01);
        chk("t5_meip_hold", 32'(meip_o), 0);
        wr(A_CLAIM, 4);
        chk("t5_meip_idle", 32'(meip_o), 0);
        @(negedge clk_i);
        chk("t5_meip_rearm", 32'(meip_o), 1);
        ack();
        chk("t5_claim2", 32'(claim_id_o), 1);
        pulse(8'h08);
        repeat (4) @(negedge clk_i);
        rd_chk("t5_pend3", A_PEND, 32'h08);
        rd_chk("t5_claim_rd", A_CLAIM, 1);

        #2 reset_i = 1'b0;
        #1;
        chk("t6_meip", 32'(meip_o), 0);
        chk("t6_rdata", rdata_o, 0);
        chk("t6_claim", 32'(claim_id_o), 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        rd_chk("t6_en", A_EN, 0);
        rd_chk("t6_pend", A_PEND, 0);
        rd_chk("t6_edge", A_EDGE, 0);
        repeat (5) @(negedge clk_i);
        chk("t6_no_meip", 32'(meip_o), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
